hci_wrr_bank_arbiter: RTL
=========================

// Module: hci_wrr_bank_arbiter
// PURPOSE
// Weighted round-robin arbiter sharing one hci_mem port (one SRAM/SCM bank) between NB_REQ initiators.
// Sits between initiator-side TCDM channels and a bank's fixed-priority shallow mux, or directly at a bank.
// Tracks the in-flight read so the 1-cycle-latency response reaches only the granted initiator.
// Per-requester weights give HWPE streams bandwidth shares without starving cores.
// PARAMETERS
// NB_REQ    4   number of requesters (>=2)
// AW        32  address width
// DW        32  data width; BE width is DW/8
// IW        8   id width
// UW        2   user width
// WEIGHT_W  4   width of each per-requester weight
// PORTS
// clk_i          in   1            clock
// rst_i          in   1            synchronous reset, active-high
// clear_i        in   1            synchronous soft clear of arbitration state
// weight_i       in   NB_REQ*WEIGHT_W  grants per turn; weight 0 is treated as 1
// in_req_i       in   NB_REQ       request per requester
// in_gnt_o       out  NB_REQ       grant per requester
// in_add_i/in_wen_i/in_be_i/in_data_i/in_id_i/in_user_i  in  NB_REQ*{AW,1,DW/8,DW,IW,UW}  request payload
// in_r_valid_o   out  NB_REQ       response valid, one-hot
// in_r_data_o/in_r_id_o/in_r_user_o  out  DW,IW,UW   response payload, broadcast to all requesters
// out_req_o      out  1            bank request
// out_gnt_i      in   1            bank grant
// out_add_o/out_wen_o/out_be_o/out_data_o/out_id_o/out_user_o  out  AW,1,DW/8,DW,IW,UW
// out_r_data_i/out_r_id_i/out_r_user_i  in  DW,IW,UW  bank response, valid 1 cycle after req&gnt
// BEHAVIOUR
// - State: ptr_q (clog2 NB_REQ) = current owner; credit_q (WEIGHT_W) = grants left for owner; resp_vld_q, resp_sel_q.
// - Reset: ptr_q=0, credit_q=eff_w[0], resp_vld_q=0, resp_sel_q=0.
// - Outputs at reset: in_gnt_o=0, in_r_valid_o=0, out_req_o=0.
// - eff_w[i] = (weight_i[i]==0) ? 1 : weight_i[i]. Sampled only on reload.
// - Winner sel (comb): first i with in_req_i[i], scanning ptr_q, ptr_q+1, ... mod NB_REQ.
// - out_req_o = |in_req_i. Payload muxed from sel; payload is don't-care when out_req_o=0.
// - in_gnt_o[i] = out_req_o & (sel==i) & out_gnt_i. Purely combinational, zero added latency.
// - Handshake (hs) = out_req_o & out_gnt_i. No state change without hs.
// - On hs with sel==ptr_q and credit_q>1: credit_q-1.
// - On hs with sel==ptr_q and credit_q<=1: ptr_q<=ptr_q+1 (wraps NB_REQ-1->0), credit_q<=eff_w[new ptr].
// - On hs with sel!=ptr_q (owner idle): ptr_q<=sel, then the same grant is charged.
//   If eff_w[sel]>1: credit_q<=eff_w[sel]-1.
//   Else: ptr_q<=sel+1 mod NB_REQ, credit_q<=eff_w[sel+1].
// - Owner dropping req does not reset credit: credits persist until owner is skipped by a hs of another requester.
// - Response: resp_vld_q<=hs, resp_sel_q<=sel every cycle.
//   in_r_valid_o[i] = resp_vld_q & (resp_sel_q==i), for reads and writes alike.
//   r_data/r_id/r_user pass straight from the bank.
// - Back-to-back grants to different requesters each get their own response cycle; there is no response buffering.
// - clear_i: ptr_q/credit_q return to reset values.
//   An in-flight response (resp_vld_q) is still delivered.
//   clear_i does not block the hs in the same cycle; that hs is charged after the clear.
// - rst_i mid-transfer drops any pending response; the requester must be reset too.
// - Weight change takes effect at the next reload only.
// TESTING
// - weights {1,1,1,1}, all req held, gnt=1 -> grants 0,1,2,3,0,... one per cycle; r_valid one-hot 1 cycle later.
// - weights {3,1,0,0}, all req, gnt=1 -> sequence 0,0,0,1,2,3,0,0,0 (weight 0 behaves as 1).
// - only req[2] held, weight[2]=2, ptr=0 -> grants 2,2,2...; ptr jumps to 2, then wraps to 3, and the scan returns to 2.
// - all req, out_gnt_i=0 for 5 cycles -> no in_gnt_o, ptr/credit frozen; resumes at the same winner when gnt=1.
// - read hs to req1 in cycle t, then clear_i at t+1 -> in_r_valid_o=4'b0010 at t+1; ptr=0, credit=eff_w[0] at t+2.
// - rst_i asserted with resp_vld_q=1 -> in_r_valid_o=0 next cycle; state equals reset values.

Source files
------------

// File: rtl/hci_wrr_bank_arbiter_if.sv
// Bundles the initiator-side and bank-side hci_mem signals of the WRR bank arbiter.
// slave is the arbiter view; master is the view of whoever drives initiators and bank.
interface hci_wrr_bank_arbiter_if #(
   parameter int NB_REQ = 4,
   parameter int AW     = 32,
   parameter int DW     = 32,
   parameter int IW     = 8,
   parameter int UW     = 2
);
   localparam int BW = DW / 8;

   logic [NB_REQ-1:0]    in_req_i;
   logic [NB_REQ-1:0]    in_gnt_o;
   logic [NB_REQ*AW-1:0] in_add_i;
   logic [NB_REQ-1:0]    in_wen_i;
   logic [NB_REQ*BW-1:0] in_be_i;
   logic [NB_REQ*DW-1:0] in_data_i;
   logic [NB_REQ*IW-1:0] in_id_i;
   logic [NB_REQ*UW-1:0] in_user_i;
   logic [NB_REQ-1:0]    in_r_valid_o;
   logic [DW-1:0]        in_r_data_o;
   logic [IW-1:0]        in_r_id_o;
   logic [UW-1:0]        in_r_user_o;

   logic                 out_req_o;
   logic                 out_gnt_i;
   logic [AW-1:0]        out_add_o;
   logic                 out_wen_o;
   logic [BW-1:0]        out_be_o;
   logic [DW-1:0]        out_data_o;
   logic [IW-1:0]        out_id_o;
   logic [UW-1:0]        out_user_o;
   logic [DW-1:0]        out_r_data_i;
   logic [IW-1:0]        out_r_id_i;
   logic [UW-1:0]        out_r_user_i;

   modport slave (
      input  in_req_i, in_add_i, in_wen_i, in_be_i, in_data_i, in_id_i, in_user_i,
      output in_gnt_o, in_r_valid_o, in_r_data_o, in_r_id_o, in_r_user_o,
      output out_req_o, out_add_o, out_wen_o, out_be_o, out_data_o, out_id_o, out_user_o,
      input  out_gnt_i, out_r_data_i, out_r_id_i, out_r_user_i
   );

   modport master (
      output in_req_i, in_add_i, in_wen_i, in_be_i, in_data_i, in_id_i, in_user_i,
      input  in_gnt_o, in_r_valid_o, in_r_data_o, in_r_id_o, in_r_user_o,
      input  out_req_o, out_add_o, out_wen_o, out_be_o, out_data_o, out_id_o, out_user_o,
      output out_gnt_i, out_r_data_i, out_r_id_i, out_r_user_i
   );
endinterface

// File: rtl/hci_wrr_bank_arbiter.sv
// Weighted round-robin arbiter sharing one hci_mem bank port between NB_REQ initiators,
// steering the 1-cycle-latency response back to the initiator that won the handshake.
module hci_wrr_bank_arbiter #(
   parameter int NB_REQ   = 4,
   parameter int AW       = 32,
   parameter int DW       = 32,
   parameter int IW       = 8,
   parameter int UW       = 2,
   parameter int WEIGHT_W = 4
) (
   input  logic                         clk_i,
   input  logic                         rst_i,
   input  logic                         clear_i,
   input  logic [NB_REQ*WEIGHT_W-1:0]   weight_i,
   hci_wrr_bank_arbiter_if.slave        bus,
   output logic [$clog2(NB_REQ)-1:0]    dbg_ptr_o,
   output logic [WEIGHT_W-1:0]          dbg_credit_o
);
   localparam int PW = $clog2(NB_REQ);
   localparam int BW = DW / 8;

   // req/gnt: a transfer happens in any cycle where out_req_o and out_gnt_i are both high;
   // payload must be stable while req is high, and nothing advances without that handshake.
   logic [PW-1:0]       ptr_q, sel, resp_sel_q, base_ptr;
   logic [WEIGHT_W-1:0] credit_q, base_credit;
   logic                resp_vld_q, hs;
   logic [WEIGHT_W-1:0] eff_w [NB_REQ];

   function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
      return (p == PW'(NB_REQ - 1)) ? '0 : p + PW'(1);
   endfunction

   always_comb begin
      for (int i = 0; i < NB_REQ; i++) begin
         eff_w[i] = (weight_i[i*WEIGHT_W +: WEIGHT_W] == '0) ? WEIGHT_W'(1)
                                                            : weight_i[i*WEIGHT_W +: WEIGHT_W];
      end
   end

   // Circular scan starting at the current owner.
   always_comb begin
      logic [PW:0] idx;
      logic        found;
      idx   = '0;
      sel   = ptr_q;
      found = 1'b0;
      for (int k = 0; k < NB_REQ; k++) begin
         idx = {1'b0, ptr_q} + (PW+1)'(k);
         if (idx >= (PW+1)'(NB_REQ)) idx = idx - (PW+1)'(NB_REQ);
         if (!found && bus.in_req_i[idx[PW-1:0]]) begin
            sel   = idx[PW-1:0];
            found = 1'b1;
         end
      end
   end

   assign bus.out_req_o = |bus.in_req_i;
   assign hs            = bus.out_req_o & bus.out_gnt_i;

   // A grant in the same cycle as clear_i is charged against the cleared state.
   always_comb begin
      base_ptr    = clear_i ? '0       : ptr_q;
      base_credit = clear_i ? eff_w[0] : credit_q;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         ptr_q      <= '0;
         credit_q   <= eff_w[0];
         resp_vld_q <= 1'b0;
         resp_sel_q <= '0;
      end else begin
         resp_vld_q <= hs;
         resp_sel_q <= sel;
         if (hs) begin
            if (sel == base_ptr) begin
               if (base_credit > WEIGHT_W'(1)) begin
                  ptr_q    <= base_ptr;
                  credit_q <= base_credit - WEIGHT_W'(1);
               end else begin
                  ptr_q    <= wrap_inc(base_ptr);
                  credit_q <= eff_w[wrap_inc(base_ptr)];
               end
            end else if (eff_w[sel] > WEIGHT_W'(1)) begin
               ptr_q    <= sel;
               credit_q <= eff_w[sel] - WEIGHT_W'(1);
            end else begin
               ptr_q    <= wrap_inc(sel);
               credit_q <= eff_w[wrap_inc(sel)];
            end
         end else if (clear_i) begin
            ptr_q    <= '0;
            credit_q <= eff_w[0];
         end
      end
   end

   always_comb begin
      bus.in_gnt_o             = '0;
      bus.in_gnt_o[sel]        = hs;
      bus.in_r_valid_o         = '0;
      bus.in_r_valid_o[resp_sel_q] = resp_vld_q;
   end

   assign bus.out_add_o   = bus.in_add_i [sel*AW +: AW];
   assign bus.out_wen_o   = bus.in_wen_i [sel];
   assign bus.out_be_o    = bus.in_be_i  [sel*BW +: BW];
   assign bus.out_data_o  = bus.in_data_i[sel*DW +: DW];
   assign bus.out_id_o    = bus.in_id_i  [sel*IW +: IW];
   assign bus.out_user_o  = bus.in_user_i[sel*UW +: UW];

   assign bus.in_r_data_o = bus.out_r_data_i;
   assign bus.in_r_id_o   = bus.out_r_id_i;
   assign bus.in_r_user_o = bus.out_r_user_i;

   assign dbg_ptr_o    = ptr_q;
   assign dbg_credit_o = credit_q;
endmodule
